// File: rtl/raster_pkg.sv
// Shared types and width helpers for the raster scan controller.
package raster_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int COLS_DEF = 320;
   localparam int ROWS_DEF = 240;

   // Coordinate port width; a count range of n needs at least one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter over 0..max_p-1 with synchronous clear; wrap_o flags the terminal count.
module wrap_counter #(
   parameter int width_p = 8,
   parameter int max_p   = 256
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               clear_i,
   input  logic               en_i,
   output logic [width_p-1:0] count_o,
   output logic               wrap_o
);

   localparam logic [width_p-1:0] LAST = width_p'(max_p - 1);

   assign wrap_o = (count_o == LAST);

   // Explicit compare-to-last wrap so non-power-of-two ranges behave.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni)    count_o <= '0;
      else if (clear_i) count_o <= '0;
      else if (en_i)    count_o <= wrap_o ? '0 : count_o + 1'b1;
   end

endmodule

// File: rtl/raster_scan_ctrl.sv
// Pass-through pixel stream controller that tags raster coordinates and frame markers.
module raster_scan_ctrl
   import raster_pkg::*;
#(
   parameter int data_width_p      = 8,
   parameter int cols_p            = COLS_DEF,
   parameter int rows_p            = ROWS_DEF,
   parameter int frame_cnt_width_p = 8
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  logic                           start_i,
   input  logic                           abort_i,
   input  logic                           continuous_i,
   input  logic                           valid_i,
   output logic                           ready_o,
   input  logic [data_width_p-1:0]        data_i,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [data_width_p-1:0]        data_o,
   output logic [cnt_w(cols_p)-1:0]       x_o,
   output logic [cnt_w(rows_p)-1:0]       y_o,
   output logic                           sof_o,
   output logic                           eol_o,
   output logic                           eof_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [frame_cnt_width_p-1:0]   frame_count_o
);

   localparam int XW = cnt_w(cols_p);
   localparam int YW = cnt_w(rows_p);

   state_e state, state_nxt;
   logic   xfer, x_last, y_last, abort_run, frame_end, done_q;

   assign xfer      = valid_i & ready_o;
   assign abort_run = (state == RUN) & abort_i;
   // Abort wins over the last pixel: the frame is not counted and no done.
   assign frame_end = xfer & x_last & y_last & ~abort_run;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state  <= IDLE;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= frame_end;
      end
   end

   always_comb begin
      state_nxt = state;
      ready_o   = 1'b0;
      valid_o   = 1'b0;
      case (state)
         IDLE: if (start_i) state_nxt = RUN;
         RUN: begin
            ready_o = ready_i;
            valid_o = valid_i;
            if (abort_i)                        state_nxt = IDLE;
            else if (frame_end && !continuous_i) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   wrap_counter #(.width_p(XW), .max_p(cols_p)) u_x (
      .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(abort_run),
      .en_i(xfer), .count_o(x_o), .wrap_o(x_last)
   );

   wrap_counter #(.width_p(YW), .max_p(rows_p)) u_y (
      .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(abort_run),
      .en_i(xfer & x_last), .count_o(y_o), .wrap_o(y_last)
   );

   wrap_counter #(.width_p(frame_cnt_width_p), .max_p(1 << frame_cnt_width_p)) u_frame (
      .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(1'b0),
      .en_i(frame_end), .count_o(frame_count_o), .wrap_o()
   );

   assign data_o = data_i;
   assign sof_o  = valid_o & (x_o == '0) & (y_o == '0);
   assign eol_o  = valid_o & x_last;
   assign eof_o  = eol_o & y_last;
   assign busy_o = (state != IDLE);
   assign done_o = done_q;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Scoreboard bench for raster_scan_ctrl on a 4x3 raster with a 2-bit frame counter.
module tb_raster_scan_ctrl;

   localparam int COLS = 4;
   localparam int ROWS = 3;
   localparam int FCW  = 2;

   logic       clk = 1'b0;
   logic       reset_ni = 1'b1;
   logic       start_i = 0, abort_i = 0, continuous_i = 0;
   logic       valid_i = 0, ready_i = 0;
   logic [7:0] data_i = '0;
   logic       ready_o, valid_o, sof_o, eol_o, eof_o, busy_o, done_o;
   logic [7:0] data_o;
   logic [1:0] x_o, y_o;
   logic [FCW-1:0] frame_count_o;

   raster_scan_ctrl #(
      .data_width_p(8), .cols_p(COLS), .rows_p(ROWS), .frame_cnt_width_p(FCW)
   ) dut (
      .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
      .continuous_i(continuous_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .x_o(x_o), .y_o(y_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
      .busy_o(busy_o), .done_o(done_o), .frame_count_o(frame_count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int d; int x; int y; int sof; int eol; int eof;
   } exp_t;
   exp_t sbq[$];

   int checks = 0, errors = 0, done_seen = 0;
   int ex = 0, ey = 0, efc = 0, est = 0, edone = 0;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Downstream monitor: every accepted pixel must match the oldest prediction.
   always @(negedge clk) begin
      if (reset_ni && valid_o && ready_o) begin
         if (sbq.size() == 0) chk("sb_unexpected_xfer", 1, 0);
         else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_data", int'(data_o), e.d);
            chk("sb_x", int'(x_o), e.x);
            chk("sb_y", int'(y_o), e.y);
            chk("sb_sof", int'(sof_o), e.sof);
            chk("sb_eol", int'(eol_o), e.eol);
            chk("sb_eof", int'(eof_o), e.eof);
         end
      end
   end

   // Drive one cycle just after a rising edge, check mid-cycle, advance the model.
   task automatic cycle(input bit st, input bit vi, input bit ri, input bit ab,
                        input bit cont, input logic [7:0] d);
      bit xfer, ndone;
      start_i = st; valid_i = vi; ready_i = ri; abort_i = ab;
      continuous_i = cont; data_i = d;
      #2;
      xfer = (est == 1) && vi && ri;
      chk("ready", int'(ready_o), int'(est == 1 && ri));
      chk("valid", int'(valid_o), int'(est == 1 && vi));
      chk("busy", int'(busy_o), int'(est != 0));
      chk("done", int'(done_o), edone);
      chk("x", int'(x_o), ex);
      chk("y", int'(y_o), ey);
      chk("fcount", int'(frame_count_o), efc);
      chk("data_pass", int'(data_o), int'(d));
      if (done_o) done_seen++;
      if (xfer)
         sbq.push_back('{int'(d), ex, ey, int'(ex == 0 && ey == 0),
                         int'(ex == COLS-1), int'(ex == COLS-1 && ey == ROWS-1)});
      ndone = 0;
      if (est == 0) begin
         if (st) est = 1;
      end else if (est == 2) begin
         est = 0;
      end else if (ab) begin
         ex = 0; ey = 0; est = 0;
      end else if (xfer) begin
         if (ex == COLS-1) begin
            ex = 0;
            if (ey == ROWS-1) begin
               ey = 0;
               efc = (efc + 1) % (1 << FCW);
               ndone = 1;
               if (!cont) est = 2;
            end else ey++;
         end else ex++;
      end
      edone = ndone;
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, int'(ready_o), 0);
      chk({tag, "_valid"}, int'(valid_o), 0);
      chk({tag, "_sof"}, int'(sof_o), 0);
      chk({tag, "_eol"}, int'(eol_o), 0);
      chk({tag, "_eof"}, int'(eof_o), 0);
      chk({tag, "_busy"}, int'(busy_o), 0);
      chk({tag, "_done"}, int'(done_o), 0);
      chk({tag, "_x"}, int'(x_o), 0);
      chk({tag, "_y"}, int'(y_o), 0);
      chk({tag, "_fc"}, int'(frame_count_o), 0);
   endtask

   int seq[5] = '{1, 2, 3, 0, 1};

   initial begin
      #1 reset_ni = 1'b0;
      #1 check_reset_outputs("rst0");
      @(posedge clk); #1;
      reset_ni = 1'b1;

      // Idle: valid upstream but no start
      repeat (3) cycle(0, 1, 1, 0, 0, 8'h11);

      // Single frame, back-to-back
      cycle(1, 0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 0, 8'(8'h20 + i));
      cycle(0, 1, 1, 0, 0, 8'h55);
      cycle(0, 1, 1, 0, 0, 8'h56);
      chk("single_fc", int'(frame_count_o), 1);
      chk("single_idle", int'(busy_o), 0);

      // Continuous: 24 pixels, two done pulses, never leaves RUN
      done_seen = 0;
      cycle(1, 0, 1, 0, 1, 8'h00);
      for (int i = 0; i < 24; i++) begin
         cycle(0, 1, 1, 0, 1, 8'(8'h40 + i));
         chk("cont_busy", int'(busy_o), 1);
      end
      cycle(0, 0, 1, 1, 1, 8'h00);
      chk("cont_done_cnt", done_seen, 2);

      // Random stalls on both sides
      cycle(1, 0, 0, 0, 1, 8'h00);
      for (int i = 0; i < 80; i++)
         cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1,
               8'($urandom_range(0, 255)));
      cycle(0, 0, 0, 1, 0, 8'h00);

      // Abort coincident with transfer 7 (x=2, y=1)
      done_seen = 0;
      cycle(1, 0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0, 8'(8'h80 + i));
      chk("pre_abort_x", int'(x_o), 2);
      chk("pre_abort_y", int'(y_o), 1);
      cycle(0, 1, 1, 1, 0, 8'h86);
      chk("abort_idle", int'(busy_o), 0);
      chk("abort_x", int'(x_o), 0);
      chk("abort_y", int'(y_o), 0);
      cycle(0, 1, 1, 0, 0, 8'h87);
      chk("abort_no_done", done_seen, 0);

      // Reset mid-frame: everything drops immediately
      cycle(1, 0, 1, 0, 1, 8'h00);
      for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 1, 8'(8'hA0 + i));
      valid_i = 1; ready_i = 1;
      #2 reset_ni = 1'b0;
      #1 check_reset_outputs("rst_mid");
      ex = 0; ey = 0; efc = 0; est = 0; edone = 0;
      @(posedge clk); #1;
      reset_ni = 1'b1;
      chk("rst_no_done", int'(done_o), 0);

      // Five continuous frames with a 2-bit frame counter
      cycle(1, 0, 1, 0, 1, 8'h00);
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 1, 8'(f * 16 + i));
         chk("fc_seq", int'(frame_count_o), seq[f]);
      end
      cycle(0, 0, 1, 1, 1, 8'h00);
      cycle(0, 0, 0, 0, 0, 8'h00);

      #3 chk("sb_leftover", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/raster_scan_ctrl.md
RASTER_SCAN_CTRL -- requirements
Module: raster_scan_ctrl

Interface
REQ-001 SHALL have parameter data_width_p, default 8: pixel data width.
REQ-002 SHALL have parameter cols_p, default 320: pixels per line, legal range ≥2.
REQ-003 SHALL have parameter rows_p, default 240: lines per frame, legal range ≥2.
REQ-004 SHALL have parameter frame_cnt_width_p, default 8: frame counter width.
REQ-005 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset_ni, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports start_i and abort_i, input, 1 each: arm a frame; cancel the current frame.
REQ-008 SHALL have port continuous_i, input, 1: when 1, the block re-arms after each frame.
REQ-009 SHALL have ports valid_i (input, 1), ready_o (output, 1) and data_i (input, data_width_p): upstream pixel handshake.
REQ-010 SHALL have ports valid_o (output, 1), ready_i (input, 1) and data_o (output, data_width_p): downstream pixel handshake.
REQ-011 SHALL have ports x_o (output, $clog2(cols_p)) and y_o (output, $clog2(rows_p)): coordinates of the current pixel.
REQ-012 SHALL have ports sof_o, eol_o and eof_o (output, 1 each): start-of-frame, end-of-line and end-of-frame markers.
REQ-013 SHALL have ports busy_o and done_o (output, 1 each): not in IDLE; one-cycle frame-complete pulse.
REQ-014 SHALL have port frame_count_o (output, frame_cnt_width_p): count of completed frames.

Function
REQ-015 SHALL implement the states IDLE, RUN and DONE.
REQ-016 IDLE SHALL go to RUN on start_i; start_i SHALL be ignored in RUN and DONE.
REQ-017 In IDLE and DONE: ready_o=0, valid_o=0; data_o SHALL equal data_i.
REQ-018 In RUN: valid_o=valid_i, ready_o=ready_i, data_o=data_i, combinationally with zero latency and no buffering.
REQ-019 A transfer SHALL be valid_i & ready_o; x/y SHALL advance only on a transfer.
REQ-020 On a transfer with x=cols_p-1, x SHALL wrap to 0 and y SHALL increment; otherwise x SHALL increment.
REQ-021 On a transfer at x=cols_p-1 and y=rows_p-1 (the last pixel):
- x and y SHALL wrap to 0;
- frame_count SHALL increment, wrapping modulo 2^frame_cnt_width_p;
- the state SHALL go to DONE if continuous_i=0, otherwise stay in RUN.
REQ-022 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE; in continuous mode done_o SHALL pulse one cycle after each last-pixel transfer while the state stays in RUN.
REQ-023 sof_o SHALL equal valid_o & (x==0) & (y==0).
REQ-024 eol_o SHALL equal valid_o & (x==cols_p-1).
REQ-025 eof_o SHALL equal eol_o & (y==rows_p-1).
REQ-026 abort_i in RUN SHALL force IDLE and clear x/y next cycle, with priority over advance and over the last-pixel transition.
- A same-cycle transfer SHALL still complete downstream.
- frame_count SHALL not increment on that transfer.
- done_o SHALL not pulse.
REQ-027 abort_i in IDLE or DONE SHALL have no effect.
REQ-028 busy_o SHALL be 1 in RUN and DONE.
REQ-029 Coordinate arithmetic SHALL use compare-to-constant wrap only, never rely on natural overflow, since cols_p and rows_p need not be powers of two.

Reset
REQ-030 reset_ni low SHALL immediately force: state IDLE, x=0, y=0, frame_count=0, done_o=0.
REQ-031 While reset_ni is low, ready_o, valid_o, sof_o, eol_o, eof_o and busy_o SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL discard the frame, with no done_o pulse.
REQ-033 Release SHALL be synchronised by the integrator; after release the block SHALL act on the first rising edge.

Structure
REQ-034 The state enum (IDLE, RUN, DONE) SHALL live in the shared package raster_pkg.
REQ-035 The port-width helper constants SHALL live in raster_pkg.
REQ-036 x, y and frame_count SHALL each be an instance of sub-module wrap_counter, parameters width_p and max_p.
REQ-037 wrap_counter SHALL have inputs clk_i, reset_ni, clear_i, en_i and outputs count_o, wrap_o.
REQ-038 wrap_counter SHALL use an asynchronous active-low reset.
REQ-039 wrap_counter SHALL give clear_i priority over en_i.

Verification (cols_p=4, rows_p=3)
REQ-040 Release reset, hold start_i=0 and valid_i=1 -> ready_o=0, valid_o=0, busy_o=0, x=y=0.
REQ-041 start_i, then 12 back-to-back transfers with ready_i=1 and continuous_i=0:
- sof_o on transfer 1;
- eol_o on transfers 4, 8 and 12; eof_o on transfer 12;
- done_o one cycle later;
- frame_count_o=1, then IDLE.
REQ-042 With continuous_i=1, stream 24 pixels -> done_o pulses twice, frame_count_o=2, busy_o stays 1, sof_o on transfers 1 and 13.
REQ-043 Random valid_i/ready_i stalls -> x/y change only on transfer cycles; data_o=data_i in the same cycle throughout.
REQ-044 abort_i coincident with transfer 7 (x=2, y=1) -> that transfer completes; next cycle IDLE, x=y=0, frame_count unchanged, no done_o.
REQ-045 frame_cnt_width_p=2, continuous_i=1, 5 frames -> frame_count_o sequence 1,2,3,0,1; reset_ni low mid-frame -> all outputs 0 immediately.
